// File: rtl/pixel_capture_if.sv
// Pixel stream bundle: one beat per accepted pixel,
// carrying data, {row,col} index and end-of-frame flag.
interface pixel_capture_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] Pix_data;
  logic [1:0]        Pix_index;
  logic              Pix_valid;
  logic              Pix_ready;
  logic              Pix_last;

  modport master (
    output Pix_data,
    output Pix_index,
    output Pix_valid,
    output Pix_last,
    input  Pix_ready
  );

  modport slave (
    input  Pix_data,
    input  Pix_index,
    input  Pix_valid,
    input  Pix_last,
    output Pix_ready
  );
endinterface

// File: rtl/pixel_capture.sv
// 2x2 frame capture from row/column ADC strobes,
// with a one-frame output buffer streamed out by valid/ready.
module pixel_capture #(
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Erase,
  input  logic              NRE_1,
  input  logic              NRE_2,
  input  logic              ADC,
  input  logic [DATA_W-1:0] Col_1,
  input  logic [DATA_W-1:0] Col_2,
  pixel_capture_if.master   pix,
  output logic [7:0]        Frame_cnt,
  output logic              Overflow,
  output logic              Row_err
);

  typedef enum logic {
    C_WAIT_R1,
    C_WAIT_R2
  } cap_st_t;

  typedef enum logic {
    O_IDLE,
    O_SEND
  } out_st_t;

  cap_st_t cst, cst_n;
  out_st_t ost, ost_n;

  logic              adc_q;
  logic              strobe;
  logic              row1;
  logic              row2;
  logic              cap_r1;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] r1c1;
  logic [DATA_W-1:0] r1c2;
  logic [DATA_W-1:0] obuf [4];
  logic [1:0]        idx;
  logic              accept;
  logic              last_acc;
  logic              buf_free;
  logic              load;

  assign strobe = ADC & ~adc_q;
  assign row1   = ~NRE_1 & NRE_2;
  assign row2   = NRE_1 & ~NRE_2;

  assign accept   = pix.Pix_valid & pix.Pix_ready;
  assign last_acc = accept & (idx == 2'd3);
  assign buf_free = (ost == O_IDLE) | last_acc;
  assign load     = done & buf_free;

  // ADC edge detector; reset high so a held strobe is not an edge
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) adc_q <= 1'b1;
    else        adc_q <= ADC;
  end

  // Capture FSM state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) cst <= C_WAIT_R1;
    else        cst <= cst_n;
  end

  // Capture FSM next state; Erase wins over any strobe
  always_comb begin
    cst_n = cst;
    if (Erase)       cst_n = C_WAIT_R1;
    else if (cap_r1) cst_n = C_WAIT_R2;
    else if (done)   cst_n = C_WAIT_R1;
  end

  // Capture FSM outputs: row-1 load, frame done, illegal strobe
  always_comb begin
    cap_r1 = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    if (strobe && !Erase) begin
      unique case (1'b1)
        row1: begin
          cap_r1 = 1'b1;
          err    = (cst == C_WAIT_R2);
        end
        row2: begin
          done = (cst == C_WAIT_R2);
          err  = (cst == C_WAIT_R1);
        end
        default: err = 1'b1;
      endcase
    end
  end

  // Row-1 holding registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r1c1 <= '0;
      r1c2 <= '0;
    end else if (cap_r1) begin
      r1c1 <= Col_1;
      r1c2 <= Col_2;
    end
  end

  // Status: error pulse, frame counter, sticky overflow
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Row_err   <= 1'b0;
      Frame_cnt <= '0;
      Overflow  <= 1'b0;
    end else begin
      Row_err <= err;
      if (load)              Frame_cnt <= Frame_cnt + 8'd1;
      if (done && !buf_free) Overflow  <= 1'b1;
    end
  end

  // Output FSM state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) ost <= O_IDLE;
    else        ost <= ost_n;
  end

  // Output FSM next state; reload on the last beat avoids a bubble
  always_comb begin
    ost_n = ost;
    if (load)          ost_n = O_SEND;
    else if (last_acc) ost_n = O_IDLE;
  end

  // Output FSM outputs: stream view of the buffer
  always_comb begin
    pix.Pix_valid = (ost == O_SEND);
    pix.Pix_index = idx;
    pix.Pix_data  = obuf[idx];
    pix.Pix_last  = (ost == O_SEND) && (idx == 2'd3);
  end

  // Output buffer and beat index
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      obuf[0] <= '0;
      obuf[1] <= '0;
      obuf[2] <= '0;
      obuf[3] <= '0;
      idx     <= '0;
    end else if (load) begin
      obuf[0] <= r1c1;
      obuf[1] <= r1c2;
      obuf[2] <= Col_1;
      obuf[3] <= Col_2;
      idx     <= '0;
    end else if (accept) begin
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_pixel_capture.sv
// Scoreboard bench for pixel_capture: expected beats are
// queued as frames are driven and popped on each handshake.
module tb_pixel_capture;

  localparam int DATA_W = 8;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Erase;
  logic              NRE_1;
  logic              NRE_2;
  logic              ADC;
  logic [DATA_W-1:0] Col_1;
  logic [DATA_W-1:0] Col_2;
  logic [7:0]        Frame_cnt;
  logic              Overflow;
  logic              Row_err;

  pixel_capture_if #(.DATA_W(DATA_W)) pix_if ();

  pixel_capture #(.DATA_W(DATA_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Erase     (Erase),
    .NRE_1     (NRE_1),
    .NRE_2     (NRE_2),
    .ADC       (ADC),
    .Col_1     (Col_1),
    .Col_2     (Col_2),
    .pix       (pix_if.master),
    .Frame_cnt (Frame_cnt),
    .Overflow  (Overflow),
    .Row_err   (Row_err)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_beats = 0;
  int n_err  = 0;
  int exp_fc = 0;
  int beats0;
  int errs0;

  logic [DATA_W+2:0] q [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Scoreboard: compare every accepted beat
  always @(negedge Clk) begin
    if (Reset && pix_if.Pix_valid && pix_if.Pix_ready) begin
      n_beats++;
      if (q.size() == 0) begin
        chk("extra_beat", 32'd1, 32'd0);
      end else begin
        chk("beat",
            {21'd0, pix_if.Pix_last, pix_if.Pix_index, pix_if.Pix_data},
            {21'd0, q.pop_front()});
      end
    end
    if (Reset && Row_err) n_err++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    repeat (8) tick();
  endtask

  task automatic push_frame(input logic [7:0] a, b, c, d);
    q.push_back({1'b0, 2'd0, a});
    q.push_back({1'b0, 2'd1, b});
    q.push_back({1'b0, 2'd2, c});
    q.push_back({1'b1, 2'd3, d});
  endtask

  task automatic set_row(input int row);
    NRE_1 = !(row == 1);
    NRE_2 = !(row == 2);
  endtask

  // row 0 = both selects high (illegal)
  task automatic strobe(input int row, input logic [7:0] c1, c2);
    set_row(row);
    Col_1 = c1;
    Col_2 = c2;
    ADC   = 1'b1;
    tick();
    ADC   = 1'b0;
    set_row(0);
    tick();
  endtask

  task automatic frame(input logic [7:0] a, b, c, d, input bit push);
    strobe(1, a, b);
    if (push) push_frame(a, b, c, d);
    strobe(2, c, d);
  endtask

  task automatic wait_idx(input logic [1:0] ix);
    int k;
    for (k = 0; k < 40; k++) begin
      if (pix_if.Pix_valid && pix_if.Pix_index == ix) break;
      tick();
    end
    chk("wait_idx", {31'd0, k < 40}, 32'd1);
  endtask

  initial begin
    Reset = 1'b0;
    Erase = 1'b1;
    ADC   = 1'b0;
    Col_1 = '0;
    Col_2 = '0;
    set_row(0);
    pix_if.Pix_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, pix_if.Pix_valid}, 32'd0);
    chk("rst_data", {24'd0, pix_if.Pix_data}, 32'd0);
    chk("rst_fcnt", {24'd0, Frame_cnt}, 32'd0);
    chk("rst_ovf", {31'd0, Overflow}, 32'd0);
    chk("rst_err", {31'd0, Row_err}, 32'd0);
    Reset = 1'b1;
    tick();
    Erase = 1'b0;
    tick();

    // normal frame with latency check
    pix_if.Pix_ready = 1'b1;
    strobe(1, 8'h11, 8'h22);
    push_frame(8'h11, 8'h22, 8'h33, 8'h44);
    set_row(2);
    Col_1 = 8'h33;
    Col_2 = 8'h44;
    ADC   = 1'b1;
    tick();
    chk("lat_valid", {31'd0, pix_if.Pix_valid}, 32'd1);
    chk("lat_idx", {30'd0, pix_if.Pix_index}, 32'd0);
    ADC = 1'b0;
    set_row(0);
    tick();
    drain();
    exp_fc++;
    chk("norm_beats", n_beats, 32'd4);
    chk("norm_fcnt", {24'd0, Frame_cnt}, exp_fc);
    chk("norm_ovf", {31'd0, Overflow}, 32'd0);

    // backpressure on index 1
    beats0 = n_beats;
    frame(8'h11, 8'h22, 8'h33, 8'h44, 1);
    exp_fc++;
    wait_idx(2'd1);
    pix_if.Pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", {24'd0, pix_if.Pix_data}, 32'h22);
      chk("bp_idx", {30'd0, pix_if.Pix_index}, 32'd1);
      chk("bp_valid", {31'd0, pix_if.Pix_valid}, 32'd1);
    end
    pix_if.Pix_ready = 1'b1;
    drain();
    chk("bp_beats", n_beats - beats0, 32'd4);

    // back-to-back: frame B completes as A's last beat leaves
    beats0 = n_beats;
    frame(8'hA0, 8'hA1, 8'hA2, 8'hA3, 1);
    strobe(1, 8'hB0, 8'hB1);
    push_frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    set_row(2);
    Col_1 = 8'hB2;
    Col_2 = 8'hB3;
    ADC   = 1'b1;
    tick();
    chk("b2b_valid", {31'd0, pix_if.Pix_valid}, 32'd1);
    chk("b2b_idx", {30'd0, pix_if.Pix_index}, 32'd0);
    chk("b2b_data", {24'd0, pix_if.Pix_data}, 32'hB0);
    ADC = 1'b0;
    set_row(0);
    tick();
    drain();
    exp_fc += 2;
    chk("b2b_beats", n_beats - beats0, 32'd8);
    chk("b2b_fcnt", {24'd0, Frame_cnt}, exp_fc);
    chk("b2b_ovf", {31'd0, Overflow}, 32'd0);

    // illegal strobes, then erase between rows
    beats0 = n_beats;
    errs0  = n_err;
    strobe(0, 8'h55, 8'h66);
    strobe(2, 8'h77, 8'h88);
    drain();
    chk("ill_err2", n_err - errs0, 32'd2);
    strobe(1, 8'h01, 8'h02);
    Erase = 1'b1;
    tick();
    Erase = 1'b0;
    strobe(2, 8'h03, 8'h04);
    drain();
    chk("ill_err3", n_err - errs0, 32'd3);
    chk("ill_beats", n_beats - beats0, 32'd0);
    chk("ill_fcnt", {24'd0, Frame_cnt}, exp_fc);

    // overflow: sink stalled, second frame dropped
    beats0 = n_beats;
    pix_if.Pix_ready = 1'b0;
    frame(8'hC0, 8'hC1, 8'hC2, 8'hC3, 1);
    frame(8'hD0, 8'hD1, 8'hD2, 8'hD3, 0);
    exp_fc++;
    tick();
    chk("ovf_flag", {31'd0, Overflow}, 32'd1);
    chk("ovf_fcnt", {24'd0, Frame_cnt}, exp_fc);
    chk("ovf_idx", {30'd0, pix_if.Pix_index}, 32'd0);
    chk("ovf_data", {24'd0, pix_if.Pix_data}, 32'hC0);
    pix_if.Pix_ready = 1'b1;
    drain();
    chk("ovf_beats", n_beats - beats0, 32'd4);
    chk("ovf_sticky", {31'd0, Overflow}, 32'd1);

    // asynchronous reset mid-stream
    frame(8'hE0, 8'hE1, 8'hE2, 8'hE3, 1);
    wait_idx(2'd2);
    Reset = 1'b0;
    q.delete();
    #2;
    chk("ar_valid", {31'd0, pix_if.Pix_valid}, 32'd0);
    chk("ar_data", {24'd0, pix_if.Pix_data}, 32'd0);
    chk("ar_idx", {30'd0, pix_if.Pix_index}, 32'd0);
    chk("ar_last", {31'd0, pix_if.Pix_last}, 32'd0);
    chk("ar_fcnt", {24'd0, Frame_cnt}, 32'd0);
    chk("ar_ovf", {31'd0, Overflow}, 32'd0);
    exp_fc = 0;
    set_row(1);
    Col_1 = 8'hF0;
    Col_2 = 8'hF1;
    ADC   = 1'b1;
    tick();
    Reset = 1'b1;
    errs0  = n_err;
    beats0 = n_beats;
    repeat (3) tick();
    ADC = 1'b0;
    set_row(0);
    tick();
    chk("hold_err", n_err - errs0, 32'd0);
    strobe(2, 8'hF2, 8'hF3);
    drain();
    chk("hold_r2err", n_err - errs0, 32'd1);
    chk("hold_beats", n_beats - beats0, 32'd0);
    chk("hold_fcnt", {24'd0, Frame_cnt}, 32'd0);

    // 256 frames wrap the counter
    for (int k = 0; k < 256; k++) begin
      frame(k[7:0], ~k[7:0], k[7:0] ^ 8'h5A, k[7:0] + 8'd3, 1);
      repeat (4) tick();
      if (k == 254) chk("fcnt_255", {24'd0, Frame_cnt}, 32'd255);
    end
    drain();
    chk("fcnt_wrap", {24'd0, Frame_cnt}, 32'd0);
    chk("q_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pixel_capture.md
Name: pixel_capture

Overview:
- Downstream consumer of the exposure/readout controller for the 2x2 pixel array.
- Watches Erase, NRE_1, NRE_2 and ADC, and samples the two column ADC buses on each ADC strobe.
- Assembles a 4-pixel frame and streams it out through a valid/ready interface.
- Uses a one-frame output buffer, so capture of the next frame overlaps draining of the current one.

Parameters:
DATA_W, 8, width of each column ADC sample and of Pix_data

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-low reset
Erase  in  1  from readout controller; high = idle/erase phase, aborts any partial frame
NRE_1  in  1  row-1 select from readout controller, active-low
NRE_2  in  1  row-2 select from readout controller, active-low
ADC  in  1  ADC conversion strobe from readout controller, active-high
Col_1  in  DATA_W  column-1 ADC result, valid while ADC=1
Col_2  in  DATA_W  column-2 ADC result, valid while ADC=1
Pix_data  out  DATA_W  pixel value
Pix_index  out  2  pixel position {row,col}: 0=r1c1, 1=r1c2, 2=r2c1, 3=r2c2
Pix_valid  out  1  Pix_data/Pix_index/Pix_last valid
Pix_ready  in  1  sink accepts the beat when Pix_valid & Pix_ready
Pix_last  out  1  high with Pix_index=3
Frame_cnt  out  8  frames delivered to output buffer, wraps 255->0
Overflow  out  1  sticky: a completed frame was dropped
Row_err  out  1  one-cycle pulse on illegal strobe

Behaviour:
- Reset (Reset=0, async): all outputs 0. Capture FSM = WAIT_R1. Output FSM = IDLE. Internal adc_q = 1, so an ADC held high at reset release is not an edge.
- Strobe detect: adc_q <= ADC every cycle. Strobe = ADC & ~adc_q. Col_1/Col_2 are sampled on the same edge that sees the strobe.
- Row decode at strobe:
  - NRE_1=0, NRE_2=1 -> row 1.
  - NRE_1=1, NRE_2=0 -> row 2.
  - Both high or both low -> Row_err=1 for one cycle; nothing captured; no state change.
- Capture FSM:
  - WAIT_R1 + row-1 strobe: store {Col_1,Col_2} in row-1 holding regs, go to WAIT_R2.
  - WAIT_R1 + row-2 strobe: Row_err pulse, discard, stay.
  - WAIT_R2 + row-2 strobe: frame complete, go to WAIT_R1.
  - WAIT_R2 + row-1 strobe: Row_err pulse, overwrite row-1 regs, stay.
  - Erase=1 forces WAIT_R1 (level-sensitive, overrides strobe in the same cycle); holding regs keep their contents.
- Frame complete at edge n:
  - Output buffer free: load the row-1 regs and the current Col_1/Col_2 (row 2) into the 4-entry output buffer at edge n. Frame_cnt +1 (mod 256). Pix_valid=1, Pix_index=0 from the cycle after edge n (latency 1 cycle from row-2 strobe sample).
  - Buffer is free if the output FSM is IDLE, or if SEND with Pix_index=3 and Pix_valid & Pix_ready in that same cycle (back-to-back: next cycle shows index 0 of the new frame, no bubble).
  - Otherwise the frame is dropped, Overflow <= 1, Frame_cnt unchanged.
- Output FSM:
  - IDLE -> SEND on load.
  - In SEND, on Pix_valid & Pix_ready: Pix_index +1. At index 3, go to IDLE and Pix_valid=0 next cycle, unless reloaded.
  - Pix_data/Pix_index/Pix_last held stable while Pix_valid & ~Pix_ready. Pix_valid never drops without acceptance.
- Overflow is cleared only by Reset.
- Erase does not affect the output FSM. A frame already in the output buffer always completes delivery.
- Reset mid-frame or mid-stream: immediate return to reset state, buffered data lost.
- Estimated RTL 150-220 lines.

Test Plan:
- Normal frame, DATA_W=8, Pix_ready=1: Erase->0; NRE_1=0 with ADC pulse, Col_1=0x11, Col_2=0x22; NRE_2=0 with ADC pulse, Col_1=0x33, Col_2=0x44 -> one cycle later 4 consecutive beats 0x11,0x22,0x33,0x44 with index 0..3, Pix_last on 0x44 only. Frame_cnt=1, Overflow=0.
- Backpressure: same frame, Pix_ready low for 5 cycles on index 1 -> Pix_data stays 0x22, index 1, valid 1; resumes on ready, still 4 beats total.
- Overflow: Pix_ready=0 throughout, two complete frames -> first frame held at index 0, Overflow=1 after second row-2 strobe, Frame_cnt=1. Then ready=1 -> only first frame's 4 pixels emitted.
- Back-to-back: second frame completes on the same edge its predecessor's index-3 beat is accepted -> next cycle index 0 of new frame, no gap, Overflow=0, Frame_cnt=2.
- Illegal strobes: ADC with NRE_1=NRE_2=1, then row-2 strobe while in WAIT_R1 -> Row_err pulses twice, no output. Erase=1 between row-1 and row-2 strobes -> following row-2 strobe also flags Row_err.
- Reset: assert Reset low mid-stream at index 2 -> outputs 0 asynchronously. ADC held high across release -> no capture, no Row_err. 256 frames -> Frame_cnt wraps to 0.
